// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 configuration sequencer.
// LUT entries are packed as {dev_addr, reg_addr, data}.
package ov5640_cfg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPwdn,
    StRst,
    StBoot,
    StFetch,
    StDly,
    StIssue,
    StWait,
    StNext,
    StDone,
    StErr
  } state_e;

  localparam int unsigned DEV_MSB  = 31;
  localparam int unsigned DEV_LSB  = 24;
  localparam int unsigned REG_MSB  = 23;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [31:0] END_MARKER      = 32'hFFFF_FFFF;
  localparam logic [7:0]  DELAY_DEV       = 8'hFF;
  localparam logic [7:0]  OV5640_DEV_ADDR = 8'h78;

endpackage

// File: rtl/ms_timer.sv
// Millisecond delay timer: load N ms, count down, flag expiry.
// O_expired rises in the last cycle of the delay so a caller leaving on it spends exactly N ms.
module ms_timer #(
  parameter int unsigned CYCLES_PER_MS = 27000
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_load,
  input  logic [7:0] I_ms,
  output logic       O_expired
);

  localparam int unsigned CycW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CYCLES_PER_MS - 1);

  logic [CycW-1:0] r_cyc;
  logic [7:0]      r_ms;
  logic            w_last;

  assign w_last    = (r_cyc == CycLast);
  assign O_expired = (r_ms == 8'd0) || ((r_ms == 8'd1) && w_last);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_cyc <= '0;
      r_ms  <= '0;
    end else if (I_load) begin
      r_cyc <= '0;
      r_ms  <= I_ms;
    end else if (r_ms != 8'd0) begin
      if (w_last) begin
        r_cyc <= '0;
        r_ms  <= r_ms - 8'd1;
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Powers up the OV5640 and walks the register LUT, issuing one I2C write per entry
// with bounded NACK retries, delay entries and an end marker.
module ov5640_cfg_sequencer
  import ov5640_cfg_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 27000,
  parameter logic [9:0]  LUT_SIZE      = 10'd300,
  parameter int unsigned T_PWDN_MS     = 5,
  parameter int unsigned T_RST_MS      = 1,
  parameter int unsigned T_BOOT_MS     = 20,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  output logic [9:0]  O_lut_index,
  input  logic [31:0] I_lut_data,
  output logic        O_i2c_req,
  output logic [7:0]  O_i2c_dev_addr,
  output logic [15:0] O_i2c_reg_addr,
  output logic [7:0]  O_i2c_wr_data,
  input  logic        I_i2c_done,
  input  logic        I_i2c_err,
  output logic        O_cmos_pwdn,
  output logic        O_cmos_rst_n,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_error,
  output logic [9:0]  O_fail_index
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  state_e            r_state, w_state_d;
  logic [9:0]        r_index, w_index_d;
  logic [RetryW-1:0] r_retry, w_retry_d;
  logic [31:0]       r_entry, w_entry_d;
  logic              r_req, w_req_d;
  logic [7:0]        r_dev, w_dev_d;
  logic [15:0]       r_reg, w_reg_d;
  logic [7:0]        r_wdata, w_wdata_d;
  logic              r_pwdn, w_pwdn_d;
  logic              r_rst_n, w_rst_n_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_error, w_error_d;
  logic [9:0]        r_fail_index, w_fail_index_d;

  logic              w_tmr_load;
  logic [7:0]        w_tmr_ms;
  logic              w_tmr_expired;

  ms_timer #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_ms_timer (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_load   (w_tmr_load),
    .I_ms     (w_tmr_ms),
    .O_expired(w_tmr_expired)
  );

  always_comb begin
    w_state_d      = r_state;
    w_index_d      = r_index;
    w_retry_d      = r_retry;
    w_entry_d      = r_entry;
    w_req_d        = r_req;
    w_dev_d        = r_dev;
    w_reg_d        = r_reg;
    w_wdata_d      = r_wdata;
    w_pwdn_d       = r_pwdn;
    w_rst_n_d      = r_rst_n;
    w_busy_d       = r_busy;
    w_done_d       = r_done;
    w_error_d      = r_error;
    w_fail_index_d = r_fail_index;
    w_tmr_load     = 1'b0;
    w_tmr_ms       = 8'd0;

    // Timed states load the timer on the transition into them.
    unique case (r_state)
      StIdle: begin
        if (I_start) begin
          w_state_d      = StPwdn;
          w_done_d       = 1'b0;
          w_error_d      = 1'b0;
          w_fail_index_d = '0;
          w_busy_d       = 1'b1;
          w_index_d      = '0;
          w_retry_d      = '0;
          w_pwdn_d       = 1'b1;
          w_rst_n_d      = 1'b0;
          w_tmr_load     = 1'b1;
          w_tmr_ms       = 8'(T_PWDN_MS);
        end
      end
      StPwdn: begin
        if (w_tmr_expired) begin
          w_state_d  = StRst;
          w_pwdn_d   = 1'b0;
          w_tmr_load = 1'b1;
          w_tmr_ms   = 8'(T_RST_MS);
        end
      end
      StRst: begin
        if (w_tmr_expired) begin
          w_state_d  = StBoot;
          w_rst_n_d  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_ms   = 8'(T_BOOT_MS);
        end
      end
      StBoot: begin
        if (w_tmr_expired) w_state_d = StFetch;
      end
      StFetch: begin
        w_entry_d = I_lut_data;
        if (I_lut_data == END_MARKER) begin
          w_state_d = StDone;
        end else if (I_lut_data[DEV_MSB:DEV_LSB] == DELAY_DEV) begin
          w_state_d  = StDly;
          w_tmr_load = 1'b1;
          w_tmr_ms   = I_lut_data[DATA_MSB:DATA_LSB];
        end else begin
          w_state_d = StIssue;
        end
      end
      StDly: begin
        if (w_tmr_expired) w_state_d = StNext;
      end
      StIssue: begin
        w_dev_d   = r_entry[DEV_MSB:DEV_LSB];
        w_reg_d   = r_entry[REG_MSB:REG_LSB];
        w_wdata_d = r_entry[DATA_MSB:DATA_LSB];
        w_req_d   = 1'b1;
        w_state_d = StWait;
      end
      StWait: begin
        if (I_i2c_done) begin
          w_req_d = 1'b0;
          if (!I_i2c_err) begin
            w_state_d = StNext;
          end else if (r_retry < RetryMax) begin
            w_retry_d = r_retry + 1'b1;
            w_state_d = StIssue;
          end else begin
            w_state_d = StErr;
          end
        end
      end
      StNext: begin
        w_retry_d = '0;
        w_index_d = r_index + 10'd1;
        // Running off the end without a marker is treated as success.
        w_state_d = (r_index + 10'd1 == LUT_SIZE) ? StDone : StFetch;
      end
      StDone: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      StErr: begin
        w_error_d      = 1'b1;
        w_fail_index_d = r_index;
        w_busy_d       = 1'b0;
        w_state_d      = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= StIdle;
      r_index      <= '0;
      r_retry      <= '0;
      r_entry      <= '0;
      r_req        <= 1'b0;
      r_dev        <= '0;
      r_reg        <= '0;
      r_wdata      <= '0;
      r_pwdn       <= 1'b1;
      r_rst_n      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_fail_index <= '0;
    end else begin
      r_state      <= w_state_d;
      r_index      <= w_index_d;
      r_retry      <= w_retry_d;
      r_entry      <= w_entry_d;
      r_req        <= w_req_d;
      r_dev        <= w_dev_d;
      r_reg        <= w_reg_d;
      r_wdata      <= w_wdata_d;
      r_pwdn       <= w_pwdn_d;
      r_rst_n      <= w_rst_n_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_fail_index <= w_fail_index_d;
    end
  end

  assign O_lut_index    = r_index;
  assign O_i2c_req      = r_req;
  assign O_i2c_dev_addr = r_dev;
  assign O_i2c_reg_addr = r_reg;
  assign O_i2c_wr_data  = r_wdata;
  assign O_cmos_pwdn    = r_pwdn;
  assign O_cmos_rst_n   = r_rst_n;
  assign O_busy         = r_busy;
  assign O_done         = r_done;
  assign O_error        = r_error;
  assign O_fail_index   = r_fail_index;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Bench for ov5640_cfg_sequencer: directed and random LUT/NACK scenarios checked
// against an entry-walk model of expected writes, delays and final status.
module tb_ov5640_cfg_sequencer;
  import ov5640_cfg_pkg::*;

  localparam int unsigned C  = 10;
  localparam int unsigned LS = 4;
  localparam int unsigned TP = 2;
  localparam int unsigned TR = 1;
  localparam int unsigned TB = 3;
  localparam int unsigned MR = 2;

  logic        clk = 1'b0;
  logic        rst, start, i2c_done, i2c_err;
  logic [9:0]  lut_index, fail_index;
  logic [31:0] lut_data;
  logic        req, pwdn, rst_n, busy, done, error;
  logic [7:0]  dev, wdata;
  logic [15:0] regad;

  logic [31:0] lut  [LS];
  int          nack [LS];

  typedef struct {
    logic [31:0] e;
    bit          err;
    int          gap;
    int          nd;
  } wr_t;
  wr_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign lut_data = (lut_index < 10'(LS)) ? lut[lut_index[1:0]] : 32'h0;

  ov5640_cfg_sequencer #(
    .CYCLES_PER_MS(C),
    .LUT_SIZE     (10'(LS)),
    .T_PWDN_MS    (TP),
    .T_RST_MS     (TR),
    .T_BOOT_MS    (TB),
    .MAX_RETRY    (MR)
  ) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_start       (start),
    .O_lut_index   (lut_index),
    .I_lut_data    (lut_data),
    .O_i2c_req     (req),
    .O_i2c_dev_addr(dev),
    .O_i2c_reg_addr(regad),
    .O_i2c_wr_data (wdata),
    .I_i2c_done    (i2c_done),
    .I_i2c_err     (i2c_err),
    .O_cmos_pwdn   (pwdn),
    .O_cmos_rst_n  (rst_n),
    .O_busy        (busy),
    .O_done        (done),
    .O_error       (error),
    .O_fail_index  (fail_index)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Walk the LUT as the sequencer should and list every write attempt it must make.
  task automatic build_model(output bit exp_err, output int exp_fail, output int exp_idx);
    int  pend = 0;
    int  nd = 0;
    bit  first = 1'b1;
    int  i = 0;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_fail = 0;
    forever begin
      if (i == LS) begin
        exp_idx = i;
        break;
      end
      if (lut[i] == END_MARKER) begin
        exp_idx = i;
        break;
      end
      if (lut[i][31:24] == DELAY_DEV) begin
        pend += int'(lut[i][7:0]);
        nd++;
        i++;
      end else begin
        int attempts = (nack[i] > MR) ? MR + 1 : nack[i] + 1;
        for (int a = 0; a < attempts; a++) begin
          wr_t w;
          w.e   = lut[i];
          w.err = (a < nack[i]);
          w.gap = (first ? TB * C : 0) + pend * C;
          w.nd  = nd;
          exp_q.push_back(w);
          first = 1'b0;
          pend  = 0;
          nd    = 0;
        end
        if (nack[i] > MR) begin
          exp_err  = 1'b1;
          exp_fail = i;
          exp_idx  = i;
          break;
        end
        i++;
      end
    end
  endtask

  task automatic run_seq(input bit busy_start);
    bit   exp_err, serving, pulsed, fin, extra_sent;
    int   exp_fail, exp_idx, c0, t_pwdn, t_rst, anchor, lat, g;
    wr_t  cur;
    build_model(exp_err, exp_fail, exp_idx);
    t_pwdn = -1; t_rst = -1; anchor = 0; lat = 0;
    serving = 1'b0; pulsed = 1'b0; fin = 1'b0; extra_sent = 1'b0;
    cur.e = '0; cur.err = 1'b0; cur.gap = 0; cur.nd = 0;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_pins", 32'({pwdn, rst_n}), 32'b10);
    check_eq("start_clear", 32'({done, error, fail_index}), 32'd0);
    for (int n = 0; n < 3000 && !fin; n++) begin
      i2c_done = 1'b0;
      i2c_err  = 1'b0;
      start    = 1'b0;
      if (t_pwdn < 0 && !pwdn) begin
        t_pwdn = cyc - c0;
        check_eq($sformatf("pwdn_fall_t=%0d", t_pwdn),
                 32'(t_pwdn >= int'(TP * C) - 2 && t_pwdn <= int'(TP * C) + 2), 32'd1);
        check_eq("rst_n_low_at_pwdn_fall", 32'(rst_n), 32'd0);
      end
      if (t_pwdn >= 0 && t_rst < 0 && rst_n) begin
        t_rst = cyc - c0;
        check_eq($sformatf("rst_low_len=%0d", t_rst - t_pwdn),
                 32'(t_rst - t_pwdn >= int'(TR * C) - 2 && t_rst - t_pwdn <= int'(TR * C) + 2),
                 32'd1);
        anchor = cyc;
      end
      if (busy_start && !extra_sent && t_rst >= 0 && cyc == anchor + 5) begin
        start      = 1'b1;
        extra_sent = 1'b1;
      end
      if (pulsed) begin
        check_eq("req_drop_after_done", 32'(req), 32'd0);
        pulsed  = 1'b0;
        serving = 1'b0;
        anchor  = cyc - 1;
      end else if (serving) begin
        check_eq("req_hold", 32'(req), 32'd1);
        check_eq("fields_hold", {dev, regad, wdata}, cur.e);
      end else if (req) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_req", 32'(req), 32'd0);
          cur.e   = {dev, regad, wdata};
          cur.err = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check_eq("wr_dev", 32'(dev), 32'(cur.e[31:24]));
          check_eq("wr_reg", 32'(regad), 32'(cur.e[23:8]));
          check_eq("wr_data", 32'(wdata), 32'(cur.e[7:0]));
          g = cyc - anchor;
          check_eq($sformatf("req_gap=%0d want=%0d", g, cur.gap),
                   32'(g >= cur.gap - 2 && g <= cur.gap + 4 + 5 * cur.nd), 32'd1);
        end
        serving = 1'b1;
        lat     = $urandom_range(0, 5);
      end else if ($urandom_range(0, 9) == 0) begin
        i2c_done = 1'b1;
        i2c_err  = 1'($urandom_range(0, 1));
      end
      if (serving && !pulsed) begin
        if (lat == 0) begin
          i2c_done = 1'b1;
          i2c_err  = cur.err;
          pulsed   = 1'b1;
        end else begin
          lat--;
        end
      end
      if (!busy) fin = 1'b1;
      tick();
    end
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    check_eq("finished_in_budget", 32'(fin), 32'd1);
    check_eq("writes_left", 32'(exp_q.size()), 32'd0);
    check_eq("end_done", 32'(done), 32'(!exp_err));
    check_eq("end_error", 32'(error), 32'(exp_err));
    check_eq("end_fail_index", 32'(fail_index), exp_err ? 32'(exp_fail) : 32'd0);
    check_eq("end_lut_index", 32'(lut_index), 32'(exp_idx));
    check_eq("end_idle", 32'({busy, req}), 32'd0);
    check_eq("end_pins_released", 32'({pwdn, rst_n}), 32'b01);
  endtask

  task automatic load_plan();
    lut[0] = 32'h7830_0882;
    lut[1] = 32'h7831_0311;
    lut[2] = 32'h7843_0061;
    lut[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < LS; i++) nack[i] = 0;
  endtask

  task automatic reset_in_wait();
    bit hit = 1'b0;
    load_plan();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      if (req) hit = 1'b1;
      else tick();
    end
    check_eq("rst_test_reached_wait", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_pins", 32'({pwdn, rst_n}), 32'b10);
    check_eq("rst_status", 32'({busy, done, error}), 32'd0);
    check_eq("rst_index", 32'(lut_index), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    load_plan();
    tick();
    tick();
    check_eq("reset_pins", 32'({pwdn, rst_n}), 32'b10);
    check_eq("reset_status", 32'({req, busy, done, error}), 32'd0);
    check_eq("reset_fields", {dev, regad, wdata}, 32'd0);
    check_eq("reset_indices", 32'({lut_index, fail_index}), 32'd0);
    rst = 1'b0;
    tick();

    load_plan();
    run_seq(1'b0);
    load_plan();
    lut[1] = 32'hFF00_0005;
    run_seq(1'b0);
    load_plan();
    nack[1] = 2;
    run_seq(1'b0);
    load_plan();
    nack[2] = 3;
    run_seq(1'b0);
    load_plan();
    run_seq(1'b1);
    reset_in_wait();
    load_plan();
    lut[3] = {OV5640_DEV_ADDR, 16'h3820, 8'h40};
    run_seq(1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < LS; i++) begin
        int k = $urandom_range(0, 99);
        int m = $urandom_range(0, 99);
        if (k < 10)      lut[i] = END_MARKER;
        else if (k < 25) lut[i] = {DELAY_DEV, 16'h0000, 8'($urandom_range(0, 6))};
        else             lut[i] = {OV5640_DEV_ADDR, 16'($urandom), 8'($urandom)};
        nack[i] = (m < 70) ? 0 : (m < 90) ? $urandom_range(1, 2) : 3;
      end
      run_seq(r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
